// File: rtl/branch_hazard_controller.sv
// ID-stage branch hazard sequencer: stall/bubble for operand hazards, wrong-path flush, memory freeze.
// Optional statistics counters are built only when BRANCH_HAZARD_STATS_EN is defined.
module branch_hazard_controller #(
  parameter int EX_ID_FWD     = 1,
  parameter int LOAD_STALL_EX = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_id_is_branch,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_redirect,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_reg_write,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_mem_read,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ready,
  output logic        o_pc_hold,
  output logic        o_ifid_hold,
  output logic        o_idex_bubble,
  output logic        o_ifid_flush,
  output logic        o_pipe_freeze,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [1:0] LP_N_LOAD = 2'(LOAD_STALL_EX);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_n;
  logic       w_freeze;
  logic       w_match_ex;
  logic       w_match_mem;
  logic       w_hl_ex;
  logic       w_hl_mem;
  logic       w_ha_ex;

  assign w_freeze    = i_dmem_req & ~i_dmem_ready;
  assign w_match_ex  = (i_ex_rd != 5'd0) &
                       (((i_ex_rd == i_id_rs1) & i_id_uses_rs1) |
                        ((i_ex_rd == i_id_rs2) & i_id_uses_rs2));
  assign w_match_mem = (i_mem_rd != 5'd0) &
                       (((i_mem_rd == i_id_rs1) & i_id_uses_rs1) |
                        ((i_mem_rd == i_id_rs2) & i_id_uses_rs2));
  assign w_hl_ex     = i_ex_reg_write & i_ex_mem_read & w_match_ex;
  assign w_hl_mem    = i_mem_mem_read & w_match_mem;
  assign w_ha_ex     = (EX_ID_FWD == 0) & i_ex_reg_write & ~i_ex_mem_read & w_match_ex;

  // Required stall length for the branch currently in ID; only consulted in IDLE.
  always_comb begin
    w_n = 2'd0;
    if (i_id_is_branch) begin
      if (w_hl_ex)                 w_n = LP_N_LOAD;
      else if (w_hl_mem | w_ha_ex) w_n = 2'd1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!w_freeze) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_n > 2'd1) begin
            w_cnt_nxt   = w_n - 2'd1;
            w_state_nxt = ST_STALL;
          end
        end
        ST_STALL: begin
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted; freeze overrides stall and flush.
  always_comb begin
    o_pc_hold     = 1'b0;
    o_ifid_hold   = 1'b0;
    o_idex_bubble = 1'b0;
    o_ifid_flush  = 1'b0;
    o_pipe_freeze = 1'b0;
    if (i_rst_n) begin
      if (w_freeze) begin
        o_pipe_freeze = 1'b1;
        o_pc_hold     = 1'b1;
        o_ifid_hold   = 1'b1;
      end else if (r_state == ST_STALL || w_n != 2'd0) begin
        o_pc_hold     = 1'b1;
        o_ifid_hold   = 1'b1;
        o_idex_bubble = 1'b1;
      end else begin
        o_ifid_flush  = i_id_redirect;
      end
    end
  end

`ifdef BRANCH_HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (o_pc_hold && r_stall_cycles != 32'hFFFF_FFFF)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (o_ifid_flush && r_flush_count != 32'hFFFF_FFFF)
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`else
  assign o_stall_cycles = 32'd0;
  assign o_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Self-checking bench for branch_hazard_controller: two instances (forwarding on / off)
// checked against a remaining-stall-cycles reference model, table vectors and corner sequences.
module tb_branch_hazard_controller;

  typedef struct packed {
    logic       br;
    logic       u1;
    logic       u2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       redir;
    logic [4:0] ex_rd;
    logic       ex_wr;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_ld;
    logic       dreq;
    logic       drdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [4:0] exp_a;
    logic [4:0] exp_b;
  } vec_t;

  // Output vector layout: {freeze, pc_hold, ifid_hold, bubble, flush}
  localparam logic [4:0] O_NONE  = 5'b00000;
  localparam logic [4:0] O_STALL = 5'b01110;
  localparam logic [4:0] O_FLUSH = 5'b00001;
  localparam logic [4:0] O_FRZ   = 5'b11100;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_id_is_branch, i_id_uses_rs1, i_id_uses_rs2, i_id_redirect;
  logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd, i_mem_rd;
  logic i_ex_reg_write, i_ex_mem_read, i_mem_mem_read, i_dmem_req, i_dmem_ready;

  logic a_pc_hold, a_ifid_hold, a_bubble, a_flush, a_freeze;
  logic b_pc_hold, b_ifid_hold, b_bubble, b_flush, b_freeze;
  logic [31:0] a_stall_cycles, a_flush_count, b_stall_cycles, b_flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  int     rem_a, rem_b;
  longint st_a, fl_a, st_b, fl_b;
  logic [4:0] act_a, act_b;

  always #5 i_clk = ~i_clk;

  branch_hazard_controller #(.EX_ID_FWD(1), .LOAD_STALL_EX(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_is_branch(i_id_is_branch), .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_redirect(i_id_redirect),
    .i_ex_rd(i_ex_rd), .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read),
    .i_mem_rd(i_mem_rd), .i_mem_mem_read(i_mem_mem_read),
    .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready),
    .o_pc_hold(a_pc_hold), .o_ifid_hold(a_ifid_hold), .o_idex_bubble(a_bubble),
    .o_ifid_flush(a_flush), .o_pipe_freeze(a_freeze),
    .o_stall_cycles(a_stall_cycles), .o_flush_count(a_flush_count)
  );

  branch_hazard_controller #(.EX_ID_FWD(0), .LOAD_STALL_EX(3)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_is_branch(i_id_is_branch), .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_redirect(i_id_redirect),
    .i_ex_rd(i_ex_rd), .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read),
    .i_mem_rd(i_mem_rd), .i_mem_mem_read(i_mem_mem_read),
    .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready),
    .o_pc_hold(b_pc_hold), .o_ifid_hold(b_ifid_hold), .o_idex_bubble(b_bubble),
    .o_ifid_flush(b_flush), .o_pipe_freeze(b_freeze),
    .o_stall_cycles(b_stall_cycles), .o_flush_count(b_flush_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic br, input logic u1, input logic u2,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic redir,
                             input logic [4:0] ex_rd, input logic ex_wr, input logic ex_ld,
                             input logic [4:0] mem_rd, input logic mem_ld,
                             input logic dreq, input logic drdy);
    in_t x;
    x.br = br; x.u1 = u1; x.u2 = u2; x.rs1 = rs1; x.rs2 = rs2; x.redir = redir;
    x.ex_rd = ex_rd; x.ex_wr = ex_wr; x.ex_ld = ex_ld;
    x.mem_rd = mem_rd; x.mem_ld = mem_ld; x.dreq = dreq; x.drdy = drdy;
    return x;
  endfunction

  // Reference model: a branch reading register r depends on a producer writing r (x0 never).
  function automatic bit reads(input in_t x, input logic [4:0] r);
    return (r != 5'd0) && ((x.u1 && x.rs1 == r) || (x.u2 && x.rs2 == r));
  endfunction

  function automatic int req_stall(input in_t x, input bit fwd, input int lst);
    if (!x.br) return 0;
    if (x.ex_wr && x.ex_ld && reads(x, x.ex_rd)) return lst;
    if (x.mem_ld && reads(x, x.mem_rd)) return 1;
    if (!fwd && x.ex_wr && !x.ex_ld && reads(x, x.ex_rd)) return 1;
    return 0;
  endfunction

  function automatic logic [4:0] model_out(input in_t x, input bit fwd, input int lst, input int rem);
    if (x.dreq && !x.drdy) return O_FRZ;
    if (rem > 0 || req_stall(x, fwd, lst) > 0) return O_STALL;
    return x.redir ? O_FLUSH : O_NONE;
  endfunction

  function automatic int model_rem(input in_t x, input bit fwd, input int lst, input int rem);
    if (x.dreq && !x.drdy) return rem;
    if (rem > 0) return rem - 1;
    if (req_stall(x, fwd, lst) > 0) return req_stall(x, fwd, lst) - 1;
    return 0;
  endfunction

  function automatic longint sat_inc(input longint v, input bit en);
    return (en && v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  task automatic drive(input in_t x);
    i_id_is_branch = x.br;   i_id_uses_rs1 = x.u1;   i_id_uses_rs2 = x.u2;
    i_id_rs1 = x.rs1;        i_id_rs2 = x.rs2;       i_id_redirect = x.redir;
    i_ex_rd = x.ex_rd;       i_ex_reg_write = x.ex_wr; i_ex_mem_read = x.ex_ld;
    i_mem_rd = x.mem_rd;     i_mem_mem_read = x.mem_ld;
    i_dmem_req = x.dreq;     i_dmem_ready = x.drdy;
  endtask

  function automatic logic [31:0] exp_stat(input longint v);
`ifdef BRANCH_HAZARD_STATS_EN
    return v[31:0];
`else
    return (v > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    rem_a = 0; rem_b = 0; st_a = 0; fl_a = 0; st_b = 0; fl_b = 0;
  endtask

  // One clock: drive after the edge, compare at negedge, advance the model at posedge.
  task automatic cycle(input in_t x);
    logic [4:0] ea, eb;
    drive(x);
    @(negedge i_clk);
    ea = model_out(x, 1'b1, 2, rem_a);
    eb = model_out(x, 1'b0, 3, rem_b);
    act_a = {a_freeze, a_pc_hold, a_ifid_hold, a_bubble, a_flush};
    act_b = {b_freeze, b_pc_hold, b_ifid_hold, b_bubble, b_flush};
    check("model_a_outputs", 32'(act_a), 32'(ea));
    check("model_b_outputs", 32'(act_b), 32'(eb));
    check("stats_a_stall", a_stall_cycles, exp_stat(st_a));
    check("stats_a_flush", a_flush_count, exp_stat(fl_a));
    check("stats_b_stall", b_stall_cycles, exp_stat(st_b));
    check("stats_b_flush", b_flush_count, exp_stat(fl_b));
    @(posedge i_clk);
    st_a = sat_inc(st_a, ea[3]); fl_a = sat_inc(fl_a, ea[0]);
    st_b = sat_inc(st_b, eb[3]); fl_b = sat_inc(fl_b, eb[0]);
    rem_a = model_rem(x, 1'b1, 2, rem_a);
    rem_b = model_rem(x, 1'b0, 3, rem_b);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0);
  endtask

  vec_t tbl[13];
  in_t  v_ld, v_rd, v_frz;
  int   cnt_hold, cnt_bub, cnt_frz;
  int   start_st;

  initial begin
    tbl[0]  = '{"no_branch",      mk(0,1,0,5,0,0, 5,1,1, 0,0, 0,0), O_NONE,  O_NONE};
    tbl[1]  = '{"load_ex_rs1",    mk(1,1,0,5,0,0, 5,1,1, 0,0, 0,0), O_STALL, O_STALL};
    tbl[2]  = '{"load_mem_rs2",   mk(1,0,1,0,7,0, 0,0,0, 7,1, 0,0), O_STALL, O_STALL};
    tbl[3]  = '{"load_mem_nouse", mk(1,0,0,0,7,0, 0,0,0, 7,1, 0,0), O_NONE,  O_NONE};
    tbl[4]  = '{"ex_x0",          mk(1,1,0,0,0,0, 0,1,0, 0,0, 0,0), O_NONE,  O_NONE};
    tbl[5]  = '{"alu_ex_x3",      mk(1,1,0,3,0,0, 3,1,0, 0,0, 0,0), O_NONE,  O_STALL};
    tbl[6]  = '{"redirect",       mk(1,1,1,1,2,1, 4,1,0, 6,1, 0,0), O_FLUSH, O_FLUSH};
    tbl[7]  = '{"hazard_redir",   mk(1,1,0,5,0,1, 5,1,1, 0,0, 0,0), O_STALL, O_STALL};
    tbl[8]  = '{"freeze_hazard",  mk(1,1,0,5,0,0, 5,1,1, 0,0, 1,0), O_FRZ,   O_FRZ};
    tbl[9]  = '{"freeze_redir",   mk(1,0,0,0,0,1, 0,0,0, 0,0, 1,0), O_FRZ,   O_FRZ};
    tbl[10] = '{"dmem_ready",     mk(1,0,0,0,0,1, 0,0,0, 0,0, 1,1), O_FLUSH, O_FLUSH};
    tbl[11] = '{"ld_no_wr",       mk(1,1,0,5,0,0, 5,0,1, 0,0, 0,0), O_NONE,  O_NONE};
    tbl[12] = '{"ld_rs2_unused",  mk(1,1,0,4,5,0, 5,1,1, 0,0, 0,0), O_NONE,  O_NONE};

    // Reset state
    i_rst_n = 1'b0;
    drive(mk(1,1,0,5,0,1, 5,1,1, 0,0, 0,0));
    model_reset();
    @(posedge i_clk); #1;
    check("reset_outputs_a", 32'({a_freeze, a_pc_hold, a_ifid_hold, a_bubble, a_flush}), 32'd0);
    check("reset_outputs_b", 32'({b_freeze, b_pc_hold, b_ifid_hold, b_bubble, b_flush}), 32'd0);
    check("reset_stats", a_stall_cycles | a_flush_count, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    idle(2);

    // Table-driven single-cycle vectors from IDLE
    foreach (tbl[i]) begin
      idle(4);
      cycle(tbl[i].in);
      check({"tbl_a_", tbl[i].name}, 32'(act_a), 32'(tbl[i].exp_a));
      check({"tbl_b_", tbl[i].name}, 32'(act_b), 32'(tbl[i].exp_b));
    end
    idle(4);

    // Load-use: 2 stall cycles, then flush in the first free cycle
    v_ld = mk(1,1,0,5,0,1, 5,1,1, 0,0, 0,0);
    v_rd = mk(1,1,0,5,0,1, 0,0,0, 0,0, 0,0);
    cycle(v_ld);
    check("lu_c1", 32'(act_a), 32'(O_STALL));
    cycle(mk(1,1,0,5,0,1, 0,0,0, 5,0, 0,0));
    check("lu_c2", 32'(act_a), 32'(O_STALL));
    cycle(v_rd);
    check("lu_c3_flush", 32'(act_a), 32'(O_FLUSH));
    idle(4);

    // Freeze during the first load-use stall cycle
    start_st = int'(a_stall_cycles);
    cnt_hold = 0; cnt_bub = 0; cnt_frz = 0;
    v_frz = mk(1,1,0,5,0,0, 5,1,1, 0,0, 1,0);
    for (int k = 0; k < 5; k++) begin
      if (k < 3)       cycle(v_frz);
      else if (k == 3) cycle(mk(1,1,0,5,0,0, 5,1,1, 0,0, 1,1));
      else             cycle('0);
      cnt_hold += act_a[3];
      cnt_bub  += act_a[1];
      cnt_frz  += act_a[4];
    end
    check("frz_freeze_cycles", 32'(cnt_frz), 32'd3);
    check("frz_bubble_cycles", 32'(cnt_bub), 32'd2);
    check("frz_hold_cycles", 32'(cnt_hold), 32'd5);
    idle(4);
`ifdef BRANCH_HAZARD_STATS_EN
    check("frz_stall_stat", a_stall_cycles - 32'(start_st), 32'd5);
`endif

    // Reset asserted in the second stall cycle
    cycle(v_ld);
    drive(v_ld);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_a", 32'({a_freeze, a_pc_hold, a_ifid_hold, a_bubble, a_flush}), 32'd0);
    check("rst_mid_b", 32'({b_freeze, b_pc_hold, b_ifid_hold, b_bubble, b_flush}), 32'd0);
    check("rst_mid_stats", a_stall_cycles | b_stall_cycles | a_flush_count, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();
    cycle(mk(1,1,0,5,0,0, 0,0,0, 0,0, 0,0));
    check("rst_release_idle", 32'(act_a), 32'(O_NONE));
    check("rst_release_idle_b", 32'(act_b), 32'(O_NONE));

`ifdef BRANCH_HAZARD_STATS_EN
    // Flush counter saturation
    force dut.r_flush_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_flush_count;
    fl_a = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) cycle(mk(1,0,0,0,0,1, 0,0,0, 0,0, 0,0));
    check("flush_saturate", a_flush_count, 32'hFFFF_FFFF);
`endif

    // Randomized stimulus against the reference model
    for (int k = 0; k < 500; k++) begin
      in_t x;
      x.br     = ($urandom_range(0, 9) < 7);
      x.u1     = 1'($urandom);
      x.u2     = 1'($urandom);
      x.rs1    = 5'($urandom_range(0, 7));
      x.rs2    = 5'($urandom_range(0, 7));
      x.redir  = 1'($urandom);
      x.ex_rd  = 5'($urandom_range(0, 7));
      x.ex_wr  = 1'($urandom);
      x.ex_ld  = 1'($urandom);
      x.mem_rd = 5'($urandom_range(0, 7));
      x.mem_ld = 1'($urandom);
      x.dreq   = ($urandom_range(0, 9) < 2);
      x.drdy   = 1'($urandom);
      cycle(x);
      if (act_a[0] && act_a[2]) check("flush_with_hold", 32'(act_a), 32'(O_FLUSH));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
